read_mem: RTL and testbench
===========================

Name: read_mem

Overview:
- Readout stage directly downstream of the capture-buffer writer in the internal logic analyzer.
- When capture completes, it snapshots the writer's address pointer and primed flag.
- It then walks the circular sample buffer from the oldest sample to the newest, presenting each sample on a valid/ready stream for the host link (UART/serializer).
- While readout is in progress it asserts a freeze so the writer stops overwriting the buffer.

Parameters:
- DATA_WIDTH, 8: sample width in bits.
- ADDR_WIDTH, 4: buffer address width.
- MEMORY_SIZE, 16: buffer depth; always equals 2**ADDR_WIDTH.

Ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse: capture finished, begin readout.
- waddr  in  ADDR_WIDTH  writer's current address; points to the next slot to be written.
- primed  in  1  writer has wrapped at least once, so all slots hold valid data.
- raddr  out  ADDR_WIDTH  buffer read address.
- rd_data  in  DATA_WIDTH  buffer read data; registered, valid 1 cycle after raddr.
- o_data  out  DATA_WIDTH  sample presented to the downstream stage.
- o_valid  out  1  o_data is valid.
- o_ready  in  1  downstream accepts the sample.
- freeze  out  1  high while not IDLE; the upstream write_enable is ANDed with !freeze.
- done  out  1  one-cycle pulse after the last sample is accepted.

Behaviour:
- Reset (reset==0 at a clk edge) values: state=IDLE, raddr=0, o_data=0, o_valid=0, freeze=0, done=0, index=0. Reset asserted mid-readout aborts immediately; no done pulse is generated.
- State encoding: IDLE, FETCH, WAIT, PRESENT, FIN.
- IDLE: on start, latch base and len:
  - base = primed ? waddr : 0.
  - len = primed ? MEMORY_SIZE : waddr. len is ADDR_WIDTH+1 bits so it can hold MEMORY_SIZE.
  - index=0. Go to FIN if len==0, else go to FETCH.
  - start is ignored in every state other than IDLE.
- FETCH: raddr <= base + index, truncated to ADDR_WIDTH bits (modulo wrap). Go to WAIT.
- WAIT: one cycle to cover the memory read latency. Go to PRESENT and register o_data <= rd_data, o_valid <= 1.
- PRESENT:
  - o_valid and o_data are held stable until o_valid && o_ready.
  - On handshake: o_valid <= 0, index++. If index == len-1, go to FIN; else go to FETCH.
  - o_ready may be asserted early or held permanently high. Minimum period is 3 cycles per sample.
- FIN: done <= 1 for exactly one cycle, then go to IDLE. freeze is high in FIN and drops on the IDLE cycle.
- freeze is combinational: (state != IDLE). It rises the cycle after start is sampled.
- Wrap-around: with base=12 and MEMORY_SIZE=16, the raddr sequence is 12,13,14,15,0,1,...,11.
- Snapshot rule: waddr and primed are sampled only on the start cycle. Later changes to either do not affect an ongoing readout.
- Simultaneous start and reset (reset==0) → reset wins.

Decomposition:
- Shared package or define file holds DATA_WIDTH, ADDR_WIDTH, MEMORY_SIZE (same values as the writer) and the state encoding constants.
- One natural sub-module: rd_addr_gen.
  - Holds base, len and index.
  - Produces raddr and a last flag.
  - The FSM stays in read_mem.

Test Plan:
- Primed readout: writer primed=1, waddr=5, buffer[i]=i; pulse start, o_ready=1 → o_data sequence 5,6,...,15,0,...,4 (16 beats), then done pulse, freeze=0.
- Unprimed partial: primed=0, waddr=3 → exactly 3 beats (0,1,2) from raddr 0,1,2, then done. No further o_valid.
- Empty buffer: primed=0, waddr=0, start → no o_valid; done pulses 2 cycles after start; freeze high for 1 cycle.
- Backpressure: o_ready low for 7 cycles mid-stream → o_data/o_valid held constant; no sample lost or duplicated; total 16 beats.
- Reset mid-readout: reset=0 after 4 beats → next cycle o_valid=0, freeze=0, no done; a fresh start restarts from the newly snapshotted waddr.
- Start while busy: second start pulse during PRESENT → ignored; beat count and order unchanged.

Source files
------------

// File: rtl/read_mem_pkg.sv
// Shared constants and state encoding for the capture-buffer readout stage.
// Sizes must match the capture-buffer writer.
package read_mem_pkg;

    localparam int unsigned DataWidth  = 8;
    localparam int unsigned AddrWidth  = 4;
    localparam int unsigned MemorySize = 16;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StPresent,
        StFin
    } state_e;

endpackage

// File: rtl/read_mem_if.sv
// Valid/ready sample stream from the readout stage toward the host link.
interface read_mem_if #(
    parameter int unsigned DATA_WIDTH = 8
) ();

    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_valid;
    logic                  o_ready;

    modport master (
        output o_data,
        output o_valid,
        input  o_ready
    );

    modport slave (
        input  o_data,
        input  o_valid,
        output o_ready
    );

endinterface

// File: rtl/read_mem_rd_addr_gen.sv
// Readout address generator: snapshots base/len at start and walks the circular buffer
// from the oldest sample to the newest.
module read_mem_rd_addr_gen #(
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned MEMORY_SIZE = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  advance,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic                  primed,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic                  empty,
    output logic                  last
);

    localparam int unsigned LenWidth = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [LenWidth-1:0]   len_q, len_d;
    logic [LenWidth-1:0]   index_q, index_d;

    // raddr always tracks base + index, so the address is already on the memory bus
    // during FETCH and the registered read data lands in time for the WAIT capture.
    always_comb begin
        base_d  = base_q;
        len_d   = len_q;
        index_d = index_q;
        raddr_d = raddr_q;
        if (load) begin
            base_d  = primed ? waddr : '0;
            len_d   = primed ? LenWidth'(MEMORY_SIZE) : {1'b0, waddr};
            index_d = '0;
            raddr_d = base_d;
        end else if (advance) begin
            index_d = index_q + LenWidth'(1);
            raddr_d = base_q + index_d[ADDR_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            base_q  <= '0;
            len_q   <= '0;
            index_q <= '0;
            raddr_q <= '0;
        end else begin
            base_q  <= base_d;
            len_q   <= len_d;
            index_q <= index_d;
            raddr_q <= raddr_d;
        end
    end

    assign raddr = raddr_q;
    assign empty = !primed && (waddr == '0);
    assign last  = (index_q == len_q - LenWidth'(1));

endmodule

// File: rtl/read_mem.sv
// Capture-buffer readout: after capture, streams every valid sample oldest-first over a
// valid/ready link while freezing the writer.
module read_mem
    import read_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DataWidth,
    parameter int unsigned ADDR_WIDTH  = AddrWidth,
    parameter int unsigned MEMORY_SIZE = MemorySize
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic                  primed,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    read_mem_if.master            stream,
    output logic                  freeze,
    output logic                  done
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] o_data_q;
    logic                  o_valid_q;
    logic                  done_q;
    logic                  load;
    logic                  advance;
    logic                  empty;
    logic                  last;

    read_mem_rd_addr_gen #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .MEMORY_SIZE (MEMORY_SIZE)
    ) u_rd_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .advance (advance),
        .waddr   (waddr),
        .primed  (primed),
        .raddr   (raddr),
        .empty   (empty),
        .last    (last)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        advance = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = empty ? StFin : StFetch;
                end
            end
            StFetch:   state_d = StWait;
            StWait:    state_d = StPresent;
            StPresent: begin
                if (o_valid_q && stream.o_ready) begin
                    advance = 1'b1;
                    state_d = last ? StFin : StFetch;
                end
            end
            StFin:     state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            o_data_q  <= '0;
            o_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == StFin);
            if (state_q == StWait) begin
                o_data_q  <= rd_data;
                o_valid_q <= 1'b1;
            end else if (advance) begin
                o_valid_q <= 1'b0;
            end
        end
    end

    assign stream.o_data  = o_data_q;
    assign stream.o_valid = o_valid_q;
    assign freeze         = (state_q != StIdle);
    assign done           = done_q;

endmodule

// File: tb/tb_read_mem.sv
// Self-checking bench for read_mem: table-driven readouts, hand-written corner sequences and
// randomized readouts against a queue-based model of the oldest-to-newest walk.
module tb_read_mem;
    import read_mem_pkg::*;

    localparam int unsigned DW = DataWidth;
    localparam int unsigned AW = AddrWidth;
    localparam int unsigned MS = MemorySize;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          primed = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rd_data = '0;
    logic          freeze;
    logic          done;

    read_mem_if #(.DATA_WIDTH(DW)) strm ();

    read_mem dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .waddr   (waddr),
        .primed  (primed),
        .raddr   (raddr),
        .rd_data (rd_data),
        .stream  (strm),
        .freeze  (freeze),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Capture buffer with a registered read port.
    logic [DW-1:0] mem [MS];
    always @(posedge clk) rd_data <= mem[raddr];

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] got_q[$];
    logic [DW-1:0] exp_q[$];
    int            done_cnt;
    bit            hold_pending = 1'b0;
    logic [DW-1:0] hold_data;

    typedef struct {
        bit            p;
        logic [AW-1:0] wa;
        int            mode;      // 0 random ready, 1 always ready, 2 seven-cycle stall
        bit            mess;      // scramble waddr/primed after start
        bit            restart;   // extra start pulse mid-readout
        int            exp_len;
        int            exp_first;
        int            exp_last;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic monitor();
        if (!reset) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", 32'(strm.o_valid), 32'd1);
                check("hold_data", 32'(strm.o_data), 32'(hold_data));
            end
            if (strm.o_valid) check("freeze_while_valid", 32'(freeze), 32'd1);
            if (strm.o_valid && strm.o_ready) got_q.push_back(strm.o_data);
            if (done) done_cnt++;
            hold_pending = strm.o_valid && !strm.o_ready;
            hold_data    = strm.o_data;
        end
    endtask

    // Sample away from the edge on negedge, then return just after the next posedge.
    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic readout(input bit p, input logic [AW-1:0] wa, input int mode,
                           input bit mess, input bit restart);
        int base;
        int len;
        base = p ? int'(wa) : 0;
        len  = p ? int'(MS) : int'(wa);
        exp_q.delete();
        for (int i = 0; i < len; i++) exp_q.push_back(mem[(base + i) % MS]);
        got_q.delete();
        done_cnt = 0;
        primed = p;
        waddr  = wa;
        strm.o_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 0; cyc < 400 && done_cnt == 0; cyc++) begin
            case (mode)
                0:       strm.o_ready = 1'($urandom_range(0, 1));
                2:       strm.o_ready = !(cyc >= 10 && cyc < 17);
                default: strm.o_ready = 1'b1;
            endcase
            if (mess) begin
                waddr  = AW'($urandom);
                primed = 1'($urandom);
            end
            if (restart) start = (cyc == 7);
            step();
        end
        start = 1'b0;
        strm.o_ready = 1'b1;
        repeat (4) step();
        check("done_once", 32'(done_cnt), 32'd1);
        check("beat_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check($sformatf("beat%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        check("freeze_after", 32'(freeze), 32'd0);
        check("valid_after", 32'(strm.o_valid), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < MS; i++) mem[i] = DW'(i);
        strm.o_ready = 1'b1;

        // Reset values
        repeat (2) step();
        check("rst_raddr", 32'(raddr), 32'd0);
        check("rst_o_data", 32'(strm.o_data), 32'd0);
        check("rst_o_valid", 32'(strm.o_valid), 32'd0);
        check("rst_freeze", 32'(freeze), 32'd0);
        check("rst_done", 32'(done), 32'd0);

        // Start together with reset: reset wins
        primed = 1'b1;
        waddr  = AW'(7);
        start  = 1'b1;
        step();
        start = 1'b0;
        check("start_in_reset_freeze", 32'(freeze), 32'd0);
        check("start_in_reset_raddr", 32'(raddr), 32'd0);
        reset = 1'b1;
        step();
        check("start_in_reset_idle", 32'(freeze), 32'd0);

        // Table-driven readouts over an identity-filled buffer
        tbl[0] = '{1'b1, AW'(5),  1, 1'b0, 1'b0, 16, 5,  4};
        tbl[1] = '{1'b0, AW'(3),  1, 1'b0, 1'b0, 3,  0,  2};
        tbl[2] = '{1'b1, AW'(12), 2, 1'b0, 1'b0, 16, 12, 11};
        tbl[3] = '{1'b1, AW'(0),  1, 1'b1, 1'b1, 16, 0,  15};
        tbl[4] = '{1'b0, AW'(15), 0, 1'b0, 1'b0, 15, 0,  14};
        tbl[5] = '{1'b1, AW'(15), 1, 1'b1, 1'b0, 16, 15, 14};
        tbl[6] = '{1'b0, AW'(1),  2, 1'b0, 1'b0, 1,  0,  0};
        for (int t = 0; t < 7; t++) begin
            readout(tbl[t].p, tbl[t].wa, tbl[t].mode, tbl[t].mess, tbl[t].restart);
            check($sformatf("tbl%0d_len", t), 32'(got_q.size()), 32'(tbl[t].exp_len));
            if (got_q.size() > 0) begin
                check($sformatf("tbl%0d_first", t), 32'(got_q[0]), 32'(tbl[t].exp_first));
                check($sformatf("tbl%0d_last", t), 32'(got_q[got_q.size() - 1]),
                      32'(tbl[t].exp_last));
            end
        end

        // Empty buffer: one FIN cycle, done two cycles after start
        primed = 1'b0;
        waddr  = '0;
        start  = 1'b1;
        step();
        start = 1'b0;
        check("empty_freeze_hi", 32'(freeze), 32'd1);
        check("empty_done_lo", 32'(done), 32'd0);
        check("empty_valid_lo", 32'(strm.o_valid), 32'd0);
        step();
        check("empty_freeze_lo", 32'(freeze), 32'd0);
        check("empty_done_hi", 32'(done), 32'd1);
        step();
        check("empty_done_pulse", 32'(done), 32'd0);

        // Reset mid-readout after four beats
        got_q.delete();
        done_cnt = 0;
        primed = 1'b1;
        waddr  = AW'(9);
        strm.o_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 0; cyc < 100 && got_q.size() < 4; cyc++) step();
        check("mid_rst_beats", 32'(got_q.size()), 32'd4);
        if (got_q.size() > 0) check("mid_rst_first", 32'(got_q[0]), 32'd9);
        reset = 1'b0;
        step();
        check("mid_rst_valid", 32'(strm.o_valid), 32'd0);
        check("mid_rst_freeze", 32'(freeze), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        reset = 1'b1;
        repeat (5) step();
        check("mid_rst_no_done", 32'(done_cnt), 32'd0);
        readout(1'b0, AW'(2), 1, 1'b0, 1'b0);
        if (got_q.size() == 2) check("mid_rst_restart", 32'(got_q[1]), 32'd1);

        // Randomized readouts over random buffer contents
        for (int r = 0; r < 12; r++) begin
            bit            p;
            logic [AW-1:0] wa;
            for (int i = 0; i < MS; i++) mem[i] = DW'($urandom);
            p  = 1'($urandom);
            wa = AW'($urandom);
            readout(p, wa, $urandom_range(0, 2), 1'($urandom), p && 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
